raster_sequencer: RTL and testbench

Control FSM that sequences one frame of the scanline rasterizer. It optionally clears the framebuffer. For each of the 240 rows it then streams all primitives from geometry memory into the row-buffer datapath and writes the finished row to the framebuffer as 2-pixel words. It sits between the MicroBlaze-facing frame control and the row-buffer / `quad` / framebuffer datapath, and owns the framebuffer write port.

---
 rtl/raster_sequencer.sv | 117 +++++++++++
 tb/tb_raster_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/raster_sequencer.sv
// raster_sequencer: sequences one frame (optional clear, then per-row primitive scan and row dump)
module raster_sequencer #(
    parameter int ROW_WIDTH  = 320,
    parameter int ROW_COUNT  = 240,
    parameter int PIPE_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        clear_req,
    input  logic [15:0] primitive_count,
    input  logic        fb_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] prim_addr,
    output logic        prim_valid,
    output logic        row_accum_en,
    output logic        row_reset,
    output logic [7:0]  current_row,
    output logic        fb_we,
    output logic        fb_sel,
    output logic [16:0] fb_waddr,
    output logic [7:0]  dump_word
);
    localparam int WORDS = ROW_WIDTH / 2;
    localparam logic [16:0] CLR_LAST = 17'(ROW_COUNT * WORDS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ROW_INIT, SCAN, DRAIN, DUMP, DONE} state_t;

    state_t state, state_nx;
    logic [15:0] count, prim_idx;
    logic [16:0] clr_cnt;
    logic [7:0] row, w, drain_cnt;
    logic [PIPE_DEPTH-1:0] acc_sr;

    assign prim_addr    = prim_idx;
    assign current_row  = row;
    assign dump_word    = w;
    assign row_accum_en = acc_sr[PIPE_DEPTH-1];

    always_comb begin
        state_nx   = state;
        busy       = state != IDLE;
        frame_done = 1'b0;
        prim_valid = 1'b0;
        row_reset  = 1'b0;
        fb_we      = 1'b0;
        fb_sel     = 1'b0;
        fb_waddr   = '0;
        case (state)
            IDLE:     if (frame_start) state_nx = clear_req ? CLEAR : ROW_INIT;
            CLEAR: begin
                fb_we    = 1'b1;
                fb_sel   = 1'b1;
                fb_waddr = clr_cnt;
                if (fb_ready && clr_cnt == CLR_LAST) state_nx = ROW_INIT;
            end
            ROW_INIT: begin
                row_reset = 1'b1;
                state_nx  = count == 16'd0 ? DUMP : SCAN;
            end
            SCAN: begin
                prim_valid = 1'b1;
                if (prim_idx == count - 16'd1) state_nx = DRAIN;
            end
            DRAIN:    if (drain_cnt == 8'(PIPE_DEPTH - 1)) state_nx = DUMP;
            DUMP: begin
                fb_we    = 1'b1;
                fb_waddr = 17'(row) * 17'(WORDS) + 17'(w);
                if (fb_ready && w == 8'(WORDS - 1))
                    state_nx = row == 8'(ROW_COUNT - 1) ? DONE : ROW_INIT;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    // Counters only move in the state that owns them; the accum pipe mirrors the fetch pipeline.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            prim_idx  <= '0;
            clr_cnt   <= '0;
            row       <= '0;
            w         <= '0;
            drain_cnt <= '0;
            acc_sr    <= '0;
        end else begin
            state  <= state_nx;
            acc_sr <= (acc_sr << 1) | PIPE_DEPTH'(prim_valid);
            case (state)
                IDLE: if (frame_start) begin
                    count   <= primitive_count;
                    row     <= '0;
                    clr_cnt <= '0;
                end
                CLEAR:    if (fb_ready) clr_cnt <= clr_cnt + 17'd1;
                ROW_INIT: begin
                    prim_idx  <= '0;
                    w         <= '0;
                    drain_cnt <= '0;
                end
                SCAN:     prim_idx <= prim_idx + 16'd1;
                DRAIN:    drain_cnt <= drain_cnt + 8'd1;
                DUMP: if (fb_ready) begin
                    if (w != 8'(WORDS - 1)) w <= w + 8'd1;
                    else if (row != 8'(ROW_COUNT - 1)) row <= row + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_sequencer.sv
// tb_raster_sequencer: directed bench for raster_sequencer with hand-derived row/clear schedules
module tb_raster_sequencer;
    logic        Clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0, clear_req = 1'b0, fb_ready = 1'b0;
    logic [15:0] primitive_count = '0;
    logic        busy, frame_done, prim_valid, row_accum_en, row_reset, fb_we, fb_sel;
    logic [15:0] prim_addr;
    logic [7:0]  current_row, dump_word;
    logic [16:0] fb_waddr;
    int checks = 0, errors = 0;

    always #5 Clk = ~Clk;

    raster_sequencer dut (
        .Clk(Clk), .reset_n(reset_n), .frame_start(frame_start), .clear_req(clear_req),
        .primitive_count(primitive_count), .fb_ready(fb_ready), .busy(busy),
        .frame_done(frame_done), .prim_addr(prim_addr), .prim_valid(prim_valid),
        .row_accum_en(row_accum_en), .row_reset(row_reset), .current_row(current_row),
        .fb_we(fb_we), .fb_sel(fb_sel), .fb_waddr(fb_waddr), .dump_word(dump_word)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, frame_done, prim_valid, row_accum_en, row_reset, fb_we, fb_sel}), 0);
        check({tag, "_dat"}, {current_row, dump_word, prim_addr}, 0);
        check({tag, "_addr"}, 32'(fb_waddr), 0);
    endtask

    // Entered in the ROW_INIT cycle of 'row'; leaves in the cycle after the row's last write.
    task automatic run_row(input int row, input int n, input int sw, input int sl, input bit poke);
        int bad = 0;
        int nd = n > 0 ? n + 2 : 0;
        logic [16:0] base = 17'(row * 160);
        check($sformatf("rinit%0d", row), {20'd0, row_reset, busy, prim_valid, fb_we, current_row},
              {20'd0, 4'b1100, 8'(row)});
        if (poke) frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int c = 1; c <= nd; c++) begin
            if (prim_valid !== (c <= n) || (c <= n && prim_addr !== 16'(c - 1)) ||
                row_accum_en !== (c >= 3) || fb_we !== 1'b0 || row_reset !== 1'b0) bad++;
            tick;
        end
        for (int k = 0; k < 160; k++) begin
            if (k == sw) repeat (sl) begin
                fb_ready = 1'b0;
                check("bp_hold", {6'd0, fb_we, dump_word, fb_waddr}, {6'd0, 1'b1, 8'(k), base + 17'(k)});
                tick;
            end
            fb_ready = 1'b1;
            if ({fb_we, fb_sel, prim_valid, row_accum_en, row_reset} !== 5'b10000 ||
                fb_waddr !== base + 17'(k) || dump_word !== 8'(k) || current_row !== 8'(row)) bad++;
            tick;
        end
        check($sformatf("row%0d", row), bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q;
        repeat (3) begin
            frame_start = 1'b1; clear_req = 1'b1; primitive_count = 16'd5; fb_ready = ~fb_ready;
            tick;
            chk_zero("rst");
        end
        frame_start = 1'b0; clear_req = 1'b0; primitive_count = '0; fb_ready = 1'b1;
        reset_n = 1'b1;
        q = 0;
        repeat (4) begin
            tick;
            if (fb_we !== 1'b0 || busy !== 1'b0 || row_accum_en !== 1'b0) q++;
        end
        check("idle_quiet", q, 0);

        // clear pass with a one-cycle stall, then the first two rows
        clear_req = 1'b1; primitive_count = 16'd3; frame_start = 1'b1;
        tick;
        frame_start = 1'b0; clear_req = 1'b0;
        q = 0;
        for (int a = 0; a < 38400; a++) begin
            if (a == 100) begin
                fb_ready = 1'b0;
                tick;
            end
            fb_ready = 1'b1;
            if ({fb_we, fb_sel, row_reset, busy} !== 4'b1101 || fb_waddr !== 17'(a)) q++;
            tick;
        end
        check("clear_seq", q, 0);
        run_row(0, 3, -1, 0, 1'b0);
        run_row(1, 3, -1, 0, 1'b0);
        reset_n = 1'b0;
        #1 chk_zero("clr_rst");
        tick;
        reset_n = 1'b1;

        // count=3 rows, then asynchronous reset in the middle of row 5's scan
        primitive_count = 16'd3; frame_start = 1'b1;
        tick;
        frame_start = 1'b0; primitive_count = '0;
        for (int r = 0; r < 5; r++) run_row(r, 3, -1, 0, 1'b0);
        check("r5_init", 32'({row_reset, current_row}), 32'({1'b1, 8'd5}));
        tick;
        tick;
        check("r5_scan", 32'({prim_valid, prim_addr}), 32'({1'b1, 16'd1}));
        #2 reset_n = 1'b0;
        #1 chk_zero("mid_rst");
        tick;
        reset_n = 1'b1;
        q = 0;
        repeat (6) begin
            tick;
            if (row_accum_en !== 1'b0 || busy !== 1'b0 || fb_we !== 1'b0) q++;
        end
        check("post_rst_quiet", q, 0);

        // full count=0 frame: backpressure at row 7 word 10, ignored frame_start at row 2
        primitive_count = 16'd0; frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int r = 0; r < 240; r++) run_row(r, 0, r == 7 ? 10 : -1, 5, r == 2);
        check("done", 32'({frame_done, busy, fb_we}), 32'(3'b110));
        tick;
        check("idle_after", 32'({frame_done, busy, fb_we}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
